// File: rtl/button_event_pkg.sv
// button_event_pkg: shared constants for the button event peripheral.
// Bit map of the conditioned inputs and the word addresses of the register file.
package button_event_pkg;

    localparam int NUM_IN = 7;

    localparam logic [1:0] ADDR_LEVEL = 2'd0;
    localparam logic [1:0] ADDR_EDGE  = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    localparam int BIT_CONTINUE      = 0;
    localparam int BIT_SET_VALUE     = 1;
    localparam int BIT_UP_DOWN_LO    = 2;
    localparam int BIT_LEFT_RIGHT_LO = 4;
    localparam int BIT_AUTO_MANUAL   = 6;

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: one input bit -- 2-flop synchroniser, stability counter,
// accepted level (stable) and a combinational pulse on the edge where stable
// goes 0->1, so the parent can capture the event on the same clock edge.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          flip;

    // The counter has seen DEBOUNCE_CYCLES-1 mismatching cycles and this one mismatches too.
    assign flip       = (sync != stable) && (cnt == CNT_MAX);
    assign rise_pulse = flip && sync;

    // Two-stage synchroniser for the asynchronous pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Any agreement restarts the count; a full run of disagreement accepts the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (flip) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_event_slave.sv
// button_event_slave: Avalon-MM slave exposing debounced levels, W1C rising-edge
// capture, an interrupt mask and (with BTN_EVT_COUNTER_EN defined) a saturating
// 8-bit event counter at address 3. Without the macro address 3 reads 0.
// Reads have a fixed latency of one cycle and return pre-write state.
module button_event_slave
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  raw_in,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        irq
);

    logic [NUM_IN-1:0] level;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] evt_q;
    logic [NUM_IN-1:0] mask_q;
    logic [NUM_IN-1:0] evt_clr;
    logic [31:0]       count_rd;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign unused_wdata = ^writedata[31:NUM_IN];

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_in
            input_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk       (clk),
                .reset     (reset),
                .raw       (raw_in[g]),
                .stable    (level[g]),
                .rise_pulse(rise[g])
            );
        end
    endgenerate

    assign evt_clr = (write && address == ADDR_EDGE) ? writedata[NUM_IN-1:0] : '0;

    // Edge capture: clear first, then OR new rises so a colliding set wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) evt_q <= '0;
        else       evt_q <= (evt_q & ~evt_clr) | rise;
    end

    // Interrupt mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             mask_q <= '0;
        else if (write && address == ADDR_MASK) mask_q <= writedata[NUM_IN-1:0];
    end

    // Registered interrupt from the current captured events and mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= |(evt_q & mask_q);
    end

`ifdef BTN_EVT_COUNTER_EN
    logic [7:0] count_q;

    // Counts cycles with at least one new rise; a clear in an event cycle leaves 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               count_q <= '0;
        else if (write && address == ADDR_COUNT) count_q <= (|rise) ? 8'd1 : 8'd0;
        else if ((|rise) && count_q != 8'hFF)    count_q <= count_q + 8'd1;
    end

    assign count_rd = {24'b0, count_q};
`else
    assign count_rd = '0;
`endif

    // Read mux over pre-write register state.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_LEVEL: rd_mux = {25'b0, level};
            ADDR_EDGE:  rd_mux = {25'b0, evt_q};
            ADDR_MASK:  rd_mux = {25'b0, mask_q};
            ADDR_COUNT: rd_mux = count_rd;
            default:    rd_mux = '0;
        endcase
    end

    // One-cycle read response; readdata holds until the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_button_event_slave.sv
// tb_button_event_slave: directed bench with DEBOUNCE_CYCLES=4. Read responses
// are checked through a queue of expected values filled when reads are issued.
module tb_button_event_slave;
    import button_event_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  raw_in = '0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    button_event_slave #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_in       (raw_in),
        .address      (address),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .irq          (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e);
        read = 1'b1;
        address = a;
        exp_q.push_back(e);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        write = 1'b1;
        address = a;
        writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Response monitor: valid must follow each read by exactly one edge.
    always @(posedge clk) begin : mon
        logic r_s;
        logic rst_s;
        logic [31:0] e;
        r_s = read;
        rst_s = reset;
        #1;
        if (!rst_s && !reset && (r_s || readdatavalid)) begin
            total++;
            assert (readdatavalid === r_s) else begin
                bad++;
                $error("FAIL rdv_latency got=%b exp=%b", readdatavalid, r_s);
            end
            if (readdatavalid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL rd_unexpected got=%h exp=none", readdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", readdata, e);
                end
            end
        end
    end

    initial begin
        // Power-on reset
        wait_n(3);
        chk("rst_rdata", readdata, 32'h0);
        chk("rst_rdv", 32'(readdatavalid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        wait_n(1);
        rd(ADDR_LEVEL, 32'h0);
        rd(ADDR_EDGE, 32'h0);
        rd(ADDR_MASK, 32'h0);
        rd(ADDR_COUNT, 32'h0);

        // Debounce: level appears exactly 5 edges after the first sample
        raw_in[BIT_SET_VALUE] = 1'b1;
        repeat (6) rd(ADDR_LEVEL, 32'h0);
        rd(ADDR_LEVEL, 32'h02);
        rd(ADDR_EDGE, 32'h02);

        // 3-cycle glitch is rejected
        raw_in[BIT_CONTINUE] = 1'b1;
        wait_n(3);
        raw_in[BIT_CONTINUE] = 1'b0;
        wait_n(8);
        rd(ADDR_LEVEL, 32'h02);
        rd(ADDR_EDGE, 32'h02);

        // Interrupt path
        wr(ADDR_EDGE, 32'h7F);
        raw_in[BIT_SET_VALUE] = 1'b0;
        wait_n(8);
        rd(ADDR_EDGE, 32'h0);
        wr(ADDR_MASK, 32'h02);
        wait_n(1);
        chk("irq_idle", 32'(irq), 32'h0);
        raw_in[BIT_SET_VALUE] = 1'b1;
        wait_n(6);
        chk("irq_with_edge", 32'(irq), 32'h0);
        wait_n(1);
        chk("irq_rise", 32'(irq), 32'h1);
        wr(ADDR_EDGE, 32'h01);
        wait_n(1);
        chk("irq_other_w1c", 32'(irq), 32'h1);
        wr(ADDR_EDGE, 32'h02);
        chk("irq_w1c_edge_n", 32'(irq), 32'h1);
        wait_n(1);
        chk("irq_w1c_drop", 32'(irq), 32'h0);

        // Set and clear of bit 4 on the same edge: set wins
        raw_in[BIT_LEFT_RIGHT_LO] = 1'b1;
        wait_n(5);
        wr(ADDR_EDGE, 32'h10);
        rd(ADDR_EDGE, 32'h10);
        wr(ADDR_EDGE, 32'h10);
        rd(ADDR_EDGE, 32'h0);

        // Bus: back-to-back reads, read concurrent with write, RO and upper bits
        rd(ADDR_LEVEL, 32'h12);
        rd(ADDR_EDGE, 32'h0);
        rd(ADDR_MASK, 32'h02);
        read = 1'b1;
        write = 1'b1;
        address = ADDR_MASK;
        writedata = 32'h55;
        exp_q.push_back(32'h02);
        @(negedge clk);
        read = 1'b0;
        write = 1'b0;
        rd(ADDR_MASK, 32'h55);
        wr(ADDR_LEVEL, 32'hFF);
        rd(ADDR_LEVEL, 32'h12);
        wr(ADDR_MASK, 32'hFFFF_FFFF);
        rd(ADDR_MASK, 32'h7F);
        wait_n(2);

`ifdef BTN_EVT_COUNTER_EN
        wr(ADDR_COUNT, 32'h0);
        rd(ADDR_COUNT, 32'h0);
        for (int i = 0; i < 300; i++) begin
            raw_in[BIT_AUTO_MANUAL] = 1'b1;
            wait_n(6);
            raw_in[BIT_AUTO_MANUAL] = 1'b0;
            wait_n(6);
            if (i == 2) rd(ADDR_COUNT, 32'h3);
        end
        rd(ADDR_COUNT, 32'hFF);
        wr(ADDR_COUNT, 32'h0);
        rd(ADDR_COUNT, 32'h0);
        raw_in[BIT_AUTO_MANUAL] = 1'b1;
        wait_n(5);
        wr(ADDR_COUNT, 32'h0);
        rd(ADDR_COUNT, 32'h1);
        raw_in[BIT_AUTO_MANUAL] = 1'b0;
        wait_n(6);
`else
        rd(ADDR_COUNT, 32'h0);
        wr(ADDR_COUNT, 32'hFF);
        rd(ADDR_COUNT, 32'h0);
        raw_in[BIT_AUTO_MANUAL] = 1'b1;
        wait_n(8);
        rd(ADDR_COUNT, 32'h0);
        raw_in[BIT_AUTO_MANUAL] = 1'b0;
        wait_n(6);
`endif

        // Mid-simulation reset with irq high, a read in flight and a debounce pending
        wr(ADDR_EDGE, 32'h7F);
        raw_in[5] = 1'b1;
        wait_n(8);
        chk("irq_pre_rst", 32'(irq), 32'h1);
        raw_in[BIT_UP_DOWN_LO + 1] = 1'b1;
        wait_n(3);
        read = 1'b1;
        address = ADDR_EDGE;
        exp_q.push_back(32'h20);
        @(posedge clk);
        #2;
        reset = 1'b1;
        read = 1'b0;
        raw_in = '0;
        #1;
        chk("mid_rst_rdata", readdata, 32'h0);
        chk("mid_rst_rdv", 32'(readdatavalid), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        wait_n(3);
        reset = 1'b0;
        wait_n(1);
        rd(ADDR_LEVEL, 32'h0);
        rd(ADDR_EDGE, 32'h0);
        rd(ADDR_MASK, 32'h0);
        rd(ADDR_COUNT, 32'h0);
        wait_n(8);
        rd(ADDR_LEVEL, 32'h0);
        chk("irq_after_rst", 32'(irq), 32'h0);
        wait_n(2);
        chk("rd_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
